// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode and phase encodings shared by the controller and the ALU
package cpu_pkg;
  typedef enum logic [2:0] {
    OP_HLT = 3'b000,
    OP_SKZ = 3'b001,
    OP_ADD = 3'b010,
    OP_AND = 3'b011,
    OP_XOR = 3'b100,
    OP_LDA = 3'b101,
    OP_STO = 3'b110,
    OP_JMP = 3'b111
  } opcode_t;

  typedef enum logic [2:0] {
    PH_INST_ADDR  = 3'd0,
    PH_INST_FETCH = 3'd1,
    PH_INST_LOAD  = 3'd2,
    PH_IDLE       = 3'd3,
    PH_OP_ADDR    = 3'd4,
    PH_OP_FETCH   = 3'd5,
    PH_ALU_OP     = 3'd6,
    PH_STORE      = 3'd7
  } phase_t;

  function automatic logic is_aluop(input logic [2:0] op);
    return op inside {OP_ADD, OP_AND, OP_XOR, OP_LDA};
  endfunction
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational control outputs from phase, live opcode/zero and the halted flag
module ctrl_decode
  import cpu_pkg::*;
(
  input  phase_t     phase,
  input  logic [2:0] opcode,
  input  logic       zero,
  input  logic       halted,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       ld_ac,
  output logic       data_e,
  output logic       wr,
  output logic       halt
);
  logic run, aluop, late, sto, jmp;
  assign run    = !halted;
  assign aluop  = is_aluop(opcode);
  assign late   = phase inside {PH_ALU_OP, PH_STORE};
  assign sto    = opcode == OP_STO;
  assign jmp    = opcode == OP_JMP;
  assign sel    = run && phase inside {PH_INST_ADDR, PH_INST_FETCH, PH_INST_LOAD, PH_IDLE};
  assign rd     = run && (phase inside {PH_INST_FETCH, PH_INST_LOAD, PH_IDLE} ||
                          (phase inside {PH_OP_FETCH, PH_ALU_OP, PH_STORE} && aluop));
  assign ld_ir  = run && phase inside {PH_INST_LOAD, PH_IDLE};
  assign inc_pc = run && (phase == PH_OP_ADDR || (phase == PH_ALU_OP && opcode == OP_SKZ && zero));
  assign ld_pc  = run && late && jmp;
  assign ld_ac  = run && phase == PH_STORE && aluop;
  assign data_e = run && late && sto;
  assign wr     = run && phase == PH_STORE && sto;
  assign halt   = halted || (phase == PH_OP_ADDR && opcode == OP_HLT);
endmodule

// File: rtl/risc_controller.sv
// risc_controller: eight-phase instruction sequencer with halt latch for the RISC CPU
module risc_controller
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       ld_ac,
  output logic       data_e,
  output logic       wr,
  output logic       halt,
  output logic [2:0] phase
);
  phase_t phase_q, phase_d;
  logic   halted_q, halted_d;
  // HLT latches at the end of phase 4 and freezes the phase there until reset
  always_comb begin
    halted_d = halted_q || (phase_q == PH_OP_ADDR && opcode == OP_HLT);
    phase_d  = halted_d ? phase_q : phase_t'(phase_q + 3'd1);
  end
  // state register; reset wins over halt entry
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= PH_INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end
  assign phase = phase_q;
  ctrl_decode u_dec (
    .phase (phase_q),
    .opcode(opcode),
    .zero  (zero),
    .halted(halted_q),
    .sel   (sel),
    .rd    (rd),
    .ld_ir (ld_ir),
    .inc_pc(inc_pc),
    .ld_pc (ld_pc),
    .ld_ac (ld_ac),
    .data_e(data_e),
    .wr    (wr),
    .halt  (halt)
  );
endmodule

// File: tb/tb_risc_controller.sv
// tb_risc_controller: scoreboard bench comparing every cycle against a phase-table model
module tb_risc_controller;
  localparam logic [2:0] HLT = 3'b000, SKZ = 3'b001, ADD = 3'b010, AND_ = 3'b011,
                         XOR_ = 3'b100, LDA = 3'b101, STO = 3'b110, JMP = 3'b111;
  logic clk = 1'b0;
  logic rst, zero;
  logic [2:0] opcode;
  logic sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt;
  logic [2:0] phase;
  int vectors = 0, miscompares = 0;
  logic [11:0] exp_q[$];
  string tag_q[$];
  logic [2:0] m_ph;
  logic m_halt;

  risc_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .ld_pc(ld_pc),
    .ld_ac(ld_ac), .data_e(data_e), .wr(wr), .halt(halt), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", tag, got, want);
    end
  endtask

  function automatic logic [11:0] model(input logic [2:0] ph, input logic h,
                                        input logic [2:0] op, input logic z);
    logic a;
    logic [8:0] c;
    a = (op == ADD) || (op == AND_) || (op == XOR_) || (op == LDA);
    if (h) return {9'b000000001, 3'd4};
    case (ph)
      3'd0:       c = 9'b100000000;
      3'd1:       c = 9'b110000000;
      3'd2, 3'd3: c = 9'b111000000;
      3'd4:       c = {3'b000, 1'b1, 4'b0000, op == HLT};
      3'd5:       c = {1'b0, a, 7'b0};
      3'd6:       c = {1'b0, a, 1'b0, op == SKZ && z, op == JMP, 1'b0, op == STO, 2'b00};
      default:    c = {1'b0, a, 2'b00, op == JMP, a, op == STO, op == STO, 1'b0};
    endcase
    return {c, ph};
  endfunction

  task automatic cyc(input logic r, input logic [2:0] op, input logic z, input string tag);
    rst = r;
    opcode = op;
    zero = z;
    exp_q.push_back(model(m_ph, m_halt, op, z));
    tag_q.push_back(tag);
    @(posedge clk);
    if (r) begin
      m_ph = 3'd0;
      m_halt = 1'b0;
    end else if (!m_halt && m_ph == 3'd4 && op == HLT) m_halt = 1'b1;
    else if (!m_halt) m_ph = m_ph + 3'd1;
    #1;
  endtask

  task automatic run(input int n, input logic [2:0] op, input logic z, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b0, op, z, tag);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      check(tag_q.pop_front(), {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt, phase},
            exp_q.pop_front());
      check("exclusive", {10'd0, ld_pc & inc_pc, wr & ~data_e}, 12'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    rst = 1'b1;
    opcode = ADD;
    zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_ph = 3'd0;
    m_halt = 1'b0;
    cyc(1'b1, ADD, 1'b0, "reset");
    cyc(1'b1, ADD, 1'b0, "reset");
    run(9, ADD, 1'b0, "add");
    cyc(1'b1, ADD, 1'b0, "reset");
    run(25, HLT, 1'b0, "hlt");
    for (int i = 0; i < 20; i++) begin
      r = $urandom;
      cyc(1'b0, r[2:0], r[3], "halted");
    end
    cyc(1'b1, ADD, 1'b0, "unhalt_rst");
    run(1, ADD, 1'b0, "after_unhalt");
    cyc(1'b1, ADD, 1'b0, "reset");
    run(8, SKZ, 1'b1, "skz_z1");
    run(8, SKZ, 1'b0, "skz_z0");
    run(8, STO, 1'b0, "sto");
    run(8, AND_, 1'b1, "and");
    run(8, XOR_, 1'b0, "xor");
    run(8, LDA, 1'b1, "lda");
    run(6, JMP, 1'b0, "jmp");
    cyc(1'b1, JMP, 1'b0, "jmp_rst_ph6");
    run(1, JMP, 1'b0, "jmp_after_rst");
    cyc(1'b1, ADD, 1'b0, "reset");
    run(4, HLT, 1'b0, "hlt_pre");
    cyc(1'b1, HLT, 1'b0, "hlt_rst_ph4");
    run(2, ADD, 1'b0, "rst_beats_hlt");
    run(7, STO, 1'b0, "sto_pre");
    cyc(1'b1, STO, 1'b0, "sto_rst_ph7");
    run(1, STO, 1'b0, "sto_abort");
    run(6, STO, 1'b0, "sto_pre2");
    cyc(1'b1, STO, 1'b0, "sto_rst_ph6");
    run(1, STO, 1'b0, "sto_abort2");
    for (int i = 0; i < 300; i++) begin
      r = $urandom;
      cyc(r[7:4] == 4'd0, r[2:0], r[3], "random");
    end
    @(negedge clk);
    check("drain", 12'(exp_q.size()), 12'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
